// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the RV32I datapath.
// The sequencer takes the master side; the datapath and memory take the slave side.
interface multicycle_ctrl_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] instr;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             addr_src;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_ctrl;
  logic [1:0]       imm_src;
  logic [1:0]       result_src;
  logic             reg_write;
  logic [2:0]       state;
  logic [1:0]       trap_cause;
  logic [WIDTH-1:0] instret;

  modport master (
    input  instr, zero, mem_ready,
    output mem_req, mem_we, addr_src, ir_write, pc_write, alu_src_a, alu_src_b,
           alu_ctrl, imm_src, result_src, reg_write, state, trap_cause, instret
  );

  modport slave (
    output instr, zero, mem_ready,
    input  mem_req, mem_we, addr_src, ir_write, pc_write, alu_src_a, alu_src_b,
           alu_ctrl, imm_src, result_src, reg_write, state, trap_cause, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer (FETCH/DECODE/EXEC/MEM/WB) sharing one ALU and one memory port.
// Define MEM_TIMEOUT_EN to trap (cause 10) when a memory access waits TIMEOUT cycles.
module multicycle_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t           state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic [WIDTH-1:0] instret_q;
  logic             retire;
  logic             timeout_hit;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       unused_instr;

  assign opcode       = bus.instr[6:0];
  assign funct3       = bus.instr[14:12];
  assign funct7_5     = bus.instr[30];
  assign unused_instr = ^{bus.instr[WIDTH-1:31], bus.instr[29:15], bus.instr[11:7]};

  logic       mem_req_c, mem_we_c, addr_src_c, ir_write_c, pc_write_c, reg_write_c;
  logic [1:0] alu_src_a_c, alu_src_b_c, result_src_c;
  logic [2:0] alu_ctrl_c;

  function automatic logic instr_legal(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_R, OP_I:   return (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b010);
      OP_LD, OP_ST: return f3 == 3'b010;
      OP_BR:        return (f3 == 3'b000) || (f3 == 3'b001);
      OP_JAL:       return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub_en);
    case (f3)
      3'b000:  return sub_en ? 3'b001 : 3'b000;
      3'b111:  return 3'b010;
      3'b110:  return 3'b011;
      3'b010:  return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_ST:   return 2'b01;
      OP_BR:   return 2'b10;
      OP_JAL:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  logic [CNT_W-1:0] wait_cnt_q;

  // Counter restarts on every entry into a memory-access state.
  always_ff @(posedge clk) begin
    if (rst)
      wait_cnt_q <= '0;
    else if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM)))
      wait_cnt_q <= '0;
    else if (mem_req_c && !bus.mem_ready)
      wait_cnt_q <= wait_cnt_q + 1'b1;
  end

  assign timeout_hit = mem_req_c && !bus.mem_ready && (wait_cnt_q == CNT_W'(TIMEOUT - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  assign retire = (state_d == S_FETCH) &&
                  ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cause_q   <= 2'b00;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (retire)
        instret_q <= instret_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_DECODE: begin
        if (instr_legal(opcode, funct3)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_R, OP_I, OP_JAL: state_d = S_WB;
          OP_LD, OP_ST:       state_d = S_MEM;
          OP_BR:              state_d = S_FETCH;
          default: begin
            state_d = S_TRAP;
            cause_d = 2'b01;
          end
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          state_d = (opcode == OP_ST) ? S_FETCH : S_WB;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    addr_src_c   = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 2'b00;
    alu_src_b_c  = 2'b00;
    alu_ctrl_c   = 3'b000;
    result_src_c = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req_c    = 1'b1;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        ir_write_c   = bus.mem_ready;
        pc_write_c   = bus.mem_ready;
      end
      S_DECODE: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b01;
      end
      S_EXEC: begin
        case (opcode)
          OP_R: begin
            alu_src_a_c = 2'b10;
            alu_ctrl_c  = alu_op(funct3, funct7_5);
          end
          OP_I: begin
            alu_src_a_c = 2'b10;
            alu_src_b_c = 2'b01;
            alu_ctrl_c  = alu_op(funct3, 1'b0);
          end
          OP_LD, OP_ST: begin
            alu_src_a_c = 2'b10;
            alu_src_b_c = 2'b01;
          end
          OP_BR: begin
            alu_src_a_c = 2'b10;
            alu_ctrl_c  = 3'b001;
            pc_write_c  = bus.zero ^ funct3[0];
          end
          OP_JAL: begin
            alu_src_a_c = 2'b01;
            alu_src_b_c = 2'b10;
            pc_write_c  = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req_c  = 1'b1;
        addr_src_c = 1'b1;
        mem_we_c   = (opcode == OP_ST);
      end
      S_WB: begin
        reg_write_c  = 1'b1;
        result_src_c = (opcode == OP_LD) ? 2'b01 : 2'b00;
      end
      default: ;
    endcase
  end

  // Enables and the memory request drop in the reset cycle itself.
  assign bus.mem_req    = mem_req_c   && !rst;
  assign bus.mem_we     = mem_we_c    && !rst;
  assign bus.ir_write   = ir_write_c  && !rst;
  assign bus.pc_write   = pc_write_c  && !rst;
  assign bus.reg_write  = reg_write_c && !rst;
  assign bus.addr_src   = addr_src_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.alu_ctrl   = alu_ctrl_c;
  assign bus.result_src = result_src_c;
  assign bus.imm_src    = imm_sel(opcode);
  assign bus.state      = state_q;
  assign bus.trap_cause = cause_q;
  assign bus.instret    = instret_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction phase plans produce expected per-cycle outputs.
module tb_multicycle_ctrl;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 16;

  localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_M = 3, PH_W = 4, PH_T = 7;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.WIDTH(WIDTH)) bus ();
  multicycle_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [2:0]       state;
    logic             mem_req;
    logic             mem_we;
    logic             addr_src;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_ctrl;
    logic [1:0]       imm_src;
    logic [1:0]       result_src;
    logic             reg_write;
    logic [1:0]       trap_cause;
    logic [WIDTH-1:0] instret;
  } obs_t;

  typedef struct {
    obs_t  exp;
    string tag;
  } rec_t;

  rec_t             sb[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  logic [WIDTH-1:0] icount;
  logic [1:0]       tcause;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit legal_ref(input logic [31:0] ins);
    logic [2:0] f3;
    f3 = ins[14:12];
    case (ins[6:0])
      OP_R, OP_I:   return (f3 == 3'd0) || (f3 == 3'd7) || (f3 == 3'd6) || (f3 == 3'd2);
      OP_LD, OP_ST: return f3 == 3'd2;
      OP_BR:        return f3 <= 3'd1;
      OP_JAL:       return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

  // Expected outputs for one cycle spent in phase ph with the given inputs.
  function automatic obs_t model(input int ph, input logic [31:0] ins, input logic z,
                                 input logic rdy, input logic rs);
    obs_t       e;
    logic [6:0] op;
    logic [2:0] f3;
    e  = '0;
    op = ins[6:0];
    f3 = ins[14:12];
    e.state      = 3'(ph);
    e.trap_cause = tcause;
    e.instret    = icount;
    if (op == OP_ST)       e.imm_src = 2'b01;
    else if (op == OP_BR)  e.imm_src = 2'b10;
    else if (op == OP_JAL) e.imm_src = 2'b11;
    if (ph == PH_F) begin
      e.mem_req    = 1'b1;
      e.alu_src_b  = 2'b10;
      e.result_src = 2'b10;
      e.ir_write   = rdy;
      e.pc_write   = rdy;
    end else if (ph == PH_D) begin
      e.alu_src_a = 2'b01;
      e.alu_src_b = 2'b01;
    end else if (ph == PH_E) begin
      if (op == OP_JAL) begin
        e.alu_src_a = 2'b01;
        e.alu_src_b = 2'b10;
        e.pc_write  = 1'b1;
      end else begin
        e.alu_src_a = 2'b10;
        e.alu_src_b = (op == OP_R || op == OP_BR) ? 2'b00 : 2'b01;
      end
      if (op == OP_BR) begin
        e.alu_ctrl = 3'b001;
        e.pc_write = z ^ f3[0];
      end else if (op == OP_R || op == OP_I) begin
        if (f3 == 3'd7)      e.alu_ctrl = 3'b010;
        else if (f3 == 3'd6) e.alu_ctrl = 3'b011;
        else if (f3 == 3'd2) e.alu_ctrl = 3'b101;
        else                 e.alu_ctrl = (op == OP_R && ins[30]) ? 3'b001 : 3'b000;
      end
    end else if (ph == PH_M) begin
      e.mem_req  = 1'b1;
      e.addr_src = 1'b1;
      e.mem_we   = (op == OP_ST);
    end else if (ph == PH_W) begin
      e.reg_write  = 1'b1;
      e.result_src = (op == OP_LD) ? 2'b01 : 2'b00;
    end
    if (rs) begin
      e.mem_req   = 1'b0;
      e.mem_we    = 1'b0;
      e.ir_write  = 1'b0;
      e.pc_write  = 1'b0;
      e.reg_write = 1'b0;
    end
    return e;
  endfunction

  task automatic cyc(input int ph, input logic [31:0] ins, input logic z, input logic rdy,
                     input logic rs, input string tag);
    rec_t r;
    bus.instr     = ins;
    bus.zero      = z;
    bus.mem_ready = rdy;
    rst           = rs;
    r.exp = model(ph, ins, z, rdy, rs);
    r.tag = tag;
    sb.push_back(r);
    @(posedge clk);
    #1;
  endtask

  task automatic trap_then_reset(input logic [31:0] ins, input string tag);
    repeat (3) cyc(PH_T, ins, rbit(), rbit(), 1'b0, tag);
    cyc(PH_T, ins, rbit(), rbit(), 1'b1, tag);
    icount = '0;
    tcause = 2'b00;
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic z, input int fwait, input int mwait,
                           input bit rst_in_mem, input string tag);
    logic [6:0] op;
    op = ins[6:0];
    for (int i = 0; i < fwait; i++) cyc(PH_F, ins, rbit(), 1'b0, 1'b0, tag);
    cyc(PH_F, ins, rbit(), 1'b1, 1'b0, tag);
    cyc(PH_D, ins, rbit(), rbit(), 1'b0, tag);
    if (!legal_ref(ins)) begin
      tcause = 2'b01;
      trap_then_reset(ins, tag);
      return;
    end
    cyc(PH_E, ins, z, rbit(), 1'b0, tag);
    if (op == OP_LD || op == OP_ST) begin
      if (rst_in_mem) begin
        cyc(PH_M, ins, rbit(), rbit(), 1'b1, tag);
        icount = '0;
        return;
      end
      for (int i = 0; i < mwait; i++) cyc(PH_M, ins, rbit(), 1'b0, 1'b0, tag);
      cyc(PH_M, ins, rbit(), 1'b1, 1'b0, tag);
      if (op == OP_LD) cyc(PH_W, ins, rbit(), rbit(), 1'b0, tag);
    end else if (op != OP_BR) begin
      cyc(PH_W, ins, rbit(), rbit(), 1'b0, tag);
    end
    icount = icount + 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 9))
      0, 1: begin w[6:0] = OP_R; w[14:12] = 3'($urandom_range(0, 3) == 0 ? 0 : ($urandom_range(0, 1) ? 7 : ($urandom_range(0, 1) ? 6 : 2))); end
      2, 3: begin w[6:0] = OP_I; w[14:12] = 3'($urandom_range(0, 1) ? 0 : ($urandom_range(0, 1) ? 7 : ($urandom_range(0, 1) ? 6 : 2))); end
      4:    begin w[6:0] = OP_LD; w[14:12] = 3'd2; end
      5:    begin w[6:0] = OP_ST; w[14:12] = 3'd2; end
      6, 7: begin w[6:0] = OP_BR; w[14:12] = 3'($urandom_range(0, 1)); end
      8:    w[6:0] = OP_JAL;
      default: begin
        case ($urandom_range(0, 3))
          0: begin w[6:0] = OP_R;  w[14:12] = 3'd1; end
          1: begin w[6:0] = OP_LD; w[14:12] = 3'd0; end
          2: begin w[6:0] = OP_BR; w[14:12] = 3'd4; end
          default: w[6:0] = 7'h37;
        endcase
      end
    endcase
    return w;
  endfunction

  initial begin
    rec_t r;
    obs_t got;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        r   = sb.pop_front();
        got = {bus.state, bus.mem_req, bus.mem_we, bus.addr_src, bus.ir_write, bus.pc_write,
               bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl, bus.imm_src, bus.result_src,
               bus.reg_write, bus.trap_cause, bus.instret};
        n_tests++;
        if (got !== r.exp) begin
          n_fail++;
          $display("FAIL %s @%0t: got state=%0d outputs=%h, required state=%0d outputs=%h",
                   r.tag, $time, got.state, got, r.exp.state, r.exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d records pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.instr     = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    icount        = '0;
    tcause        = 2'b00;
    @(posedge clk);
    #1;
    cyc(PH_F, 32'h0000_0013, 1'b0, 1'b1, 1'b1, "reset");

    run_instr(32'h0020_81B3, 1'b0, 0, 0, 1'b0, "add");
    run_instr(32'h0080_A283, 1'b0, 0, 3, 1'b0, "lw_wait3");
    run_instr(32'h0020_8463, 1'b1, 0, 0, 1'b0, "beq_taken");
    run_instr(32'h0020_9463, 1'b1, 0, 0, 1'b0, "bne_zero");
    run_instr(32'h4020_81B3, 1'b0, 1, 0, 1'b0, "sub");
    run_instr(32'h0000_007F, 1'b0, 0, 0, 1'b0, "illegal_op");
    run_instr(32'h0080_006F, 1'b0, 0, 0, 1'b0, "jal");
    run_instr(32'h0020_A023, 1'b0, 0, 0, 1'b1, "sw_reset_mem");
    run_instr(32'h0020_A023, 1'b0, 2, 1, 1'b0, "sw");
`ifdef MEM_TIMEOUT_EN
    run_instr(32'h0020_81B3, 1'b0, TIMEOUT - 1, 0, 1'b0, "ready_last_cycle");
    for (int i = 0; i < TIMEOUT; i++) cyc(PH_F, 32'h0020_81B3, 1'b0, 1'b0, 1'b0, "fetch_timeout");
    tcause = 2'b10;
    trap_then_reset(32'h0020_81B3, "fetch_timeout");
`else
    run_instr(32'h0020_81B3, 1'b0, 20, 0, 1'b0, "long_wait");
`endif

    for (int n = 0; n < 150; n++) begin
      run_instr(rand_instr(), rbit(),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
                ($urandom_range(0, 19) == 0), "random");
    end

    #2;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d records left unchecked, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the RV32I core: replaces single-cycle decode with a FETCH/DECODE/EXEC/MEM/WB state machine, so one ALU and one unified memory port serve every instruction phase. Sits beside the register file, ALU and instruction register; drives their mux selects and write enables from the current state and the latched instruction word. Handles variable-latency memory with a req/ready handshake and counts retired instructions.

## Interface
- WIDTH, 32, instruction and instret width
- TIMEOUT, 16, memory wait limit in cycles (used only with MEM_TIMEOUT_EN)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- instr  in  WIDTH  instruction register contents
- zero  in  1  ALU zero flag, valid in EXEC
- mem_ready  in  1  memory completes access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  store when high
- addr_src  out  1  0 = PC, 1 = ALU-out register
- ir_write  out  1  latch instr and old PC
- pc_write  out  1  load PC
- alu_src_a  out  2  00 PC, 01 old PC, 10 rs1
- alu_src_b  out  2  00 rs2, 01 immediate, 10 constant 4
- alu_ctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  out  2  00 I, 01 S, 10 B, 11 J
- result_src  out  2  00 ALU-out register, 01 read data, 10 ALU result direct
- reg_write  out  1  register file write enable
- state  out  3  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 7
- trap_cause  out  2  00 none, 01 illegal instruction, 10 memory timeout
- instret  out  WIDTH  retired-instruction count

## Operation
- FETCH: mem_req=1, addr_src=0, alu a=PC b=4 add, result_src=10. On mem_ready: ir_write=1, pc_write=1, -> DECODE; else stay.
- DECODE: alu a=old PC b=imm add (branch/jump target into ALU-out). Opcode not in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111} -> TRAP (cause 01); else -> EXEC.
- EXEC: R-type a=rs1 b=rs2; I-ALU a=rs1 b=imm -> WB. Load/store a=rs1 b=imm add -> MEM. Branch a=rs1 b=rs2 sub, pc_write = zero XOR funct3[0], result_src=00 -> FETCH. JAL pc_write=1 result_src=00, a=old PC b=4 add -> WB.
- alu_ctrl: funct3 000 -> add (sub if R-type and funct7[5]), 111 and, 110 or, 010 slt; any other funct3 on R/I-ALU, branch funct3 not 000/001, load/store funct3 not 010 -> TRAP cause 01 from DECODE.
- MEM: mem_req=1, addr_src=1, mem_we=1 for store. Hold until mem_ready; store -> FETCH, load -> WB.
- WB: reg_write=1; result_src=01 for load, 00 otherwise -> FETCH.
- TRAP: all enables/req 0; remains until rst.
- imm_src decoded from opcode in every state; unused states drive 00.
- instret increments by 1 on each transition into FETCH from EXEC, MEM or WB; wraps 2^WIDTH-1 -> 0.

## Timing
- Outputs combinational from state register and instr; state, instret, trap_cause, timeout counter registered.
- While rst high: mem_req, mem_we, ir_write, pc_write, reg_write forced 0 same cycle; on next edge state=FETCH, instret=0, trap_cause=00, counter=0.
- Reset mid-MEM: request dropped in reset cycle, no partial write retried; first cycle after reset is FETCH with mem_req=1.
- Cycle counts with zero-wait memory (mem_ready high on first request cycle): branch 3, store 4, R/I/JAL 4, load 5.
- Each memory wait cycle adds one cycle; all other outputs stable while waiting.
- mem_ready outside FETCH/MEM ignored.

## Configuration
- MEM_TIMEOUT_EN defined: counter cleared on entering FETCH or MEM, increments each cycle mem_req high without mem_ready; when counter reaches TIMEOUT-1 and mem_ready still low, next state TRAP with cause 10. mem_ready on that same cycle wins (normal transition).
- Undefined: no counter, waits indefinitely; trap_cause never 10.

## Test plan
- Reset then add x3,x1,x2 (0x002081B3), mem_ready always 1 -> states 0,1,2,4,0; reg_write only in WB, alu_ctrl=000; instret=1 after 4 cycles.
- lw x5,8(x1) (0x0080A283), mem_ready low 3 cycles in MEM -> MEM held 4 cycles, mem_we=0, addr_src=1, WB result_src=01; total 8 cycles.
- beq taken (zero=1, 0x00208463) -> pc_write=1 in EXEC, alu_ctrl=001; bne with zero=1 -> pc_write=0; both 3 cycles.
- Opcode 0x0000007F -> TRAP at cycle 2, trap_cause=01, mem_req=0 until rst; rst returns state 0, instret 0.
- MEM_TIMEOUT_EN, TIMEOUT=16, mem_ready held 0 in FETCH -> TRAP after 16 cycles, cause 10; mem_ready on 16th cycle -> DECODE.
- rst pulsed during store MEM cycle -> mem_we=0 that cycle, next state FETCH, instret=0.
